// File: rtl/cbfp_ctrl_pkg.sv
// Shared types and constants for the CBFP block sequencer.
package cbfp_ctrl_pkg;

  // Default width of leading-zero counts / shift amount.
  localparam int cbfp_lzc_w     = 5;
  // Default saturation limit for the block shift (din_size - dout_size).
  localparam int cbfp_max_shift = 12;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cbfp_blk_ctrl_if.sv
// Beat-stream / buffer-control bundle between the CBFP datapath and the block sequencer.
// master: datapath/stimulus side, slave: cbfp_blk_ctrl.
interface cbfp_blk_ctrl_if #(
  parameter int addr_w = 2,
  parameter int lzc_w  = 5
);
  logic              valid_in;
  logic [lzc_w-1:0]  beat_lzc;
  logic              rd_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [addr_w-1:0] wr_addr;
  logic              rd_en;
  logic              rd_bank;
  logic [addr_w-1:0] rd_addr;
  logic              valid_out;
  logic [lzc_w-1:0]  shift_amt;
  logic              blk_last;
  logic              overflow;
  logic [15:0]       blk_count;

  modport master (
    output valid_in, beat_lzc, rd_ready,
    input  wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           valid_out, shift_amt, blk_last, overflow, blk_count
  );

  modport slave (
    input  valid_in, beat_lzc, rd_ready,
    output wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           valid_out, shift_amt, blk_last, overflow, blk_count
  );
endinterface

// File: rtl/cbfp_blk_ctrl_bank_fsm.sv
// Per-bank state of the ping-pong sample buffer plus the latched block exponent.
//
// state   | meaning
// EMPTY   | bank free, no beats written
// FILLING | at least one beat of the current block written
// FULL    | block complete, exponent latched, waiting for read-out
// READING | block being streamed to the downstream stage
module cbfp_bank_fsm
  import cbfp_ctrl_pkg::*;
#(
  parameter int lzc_w = cbfp_lzc_w
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             set_fill,
  input  logic             set_full,
  input  logic             start_read,
  input  logic             done_read,
  input  logic [lzc_w-1:0] exp_in,
  output bank_state_t      state,
  output logic [lzc_w-1:0] exp_out
);

  bank_state_t      state_q;
  logic [lzc_w-1:0] exp_q;

  // Bank lifecycle; a bank finishing read-out may be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      exp_q   <= '0;
    end else begin
      case (state_q)
        EMPTY:   if (set_fill) state_q <= FILLING;
        FILLING: if (set_full) begin
                   state_q <= FULL;
                   exp_q   <= exp_in;
                 end
        FULL:    if (start_read) state_q <= READING;
        READING: if (done_read) state_q <= set_fill ? FILLING : EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign state   = state_q;
  assign exp_out = exp_q;

endmodule

// File: rtl/cbfp_blk_ctrl.sv
// CBFP block sequencer: groups input beats into blocks, steers them into a
// two-bank ping-pong buffer, tracks the block minimum LZC and reads each
// completed block out with its shift amount.
// Optional block statistics counter: define CBFP_STATS_EN.
module cbfp_blk_ctrl
  import cbfp_ctrl_pkg::*;
#(
  parameter int array_size    = 16,
  parameter int beats_per_blk = 4,
  parameter int lzc_w         = cbfp_lzc_w,
  parameter int max_shift     = cbfp_max_shift
) (
  input  logic           clk,
  input  logic           rstn,
  cbfp_blk_ctrl_if.slave bus
);

  localparam int                addr_w    = $clog2(beats_per_blk);
  localparam logic [addr_w-1:0] last_beat = addr_w'(beats_per_blk - 1);
  localparam logic [lzc_w-1:0]  shift_sat = lzc_w'(max_shift);

  if (beats_per_blk < 2 || (beats_per_blk & (beats_per_blk - 1)) != 0 || array_size < 1) begin : g_bad_cfg
    $error("cbfp_blk_ctrl: beats_per_blk must be a power of 2 >= 2");
  end

  bank_state_t      bank_st  [2];
  logic [lzc_w-1:0] bank_exp [2];
  logic [1:0]       set_fill, set_full, start_read, done_read;
  logic [lzc_w-1:0] blk_exp;

  logic              wr_ok, wr_en, wr_last, rd_en, rd_done, any_reading;
  logic [addr_w-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [lzc_w-1:0]  run_min_q, run_min_d;
  logic              overflow_q, overflow_d;
  logic              valid_out_q, valid_out_d;
  logic [lzc_w-1:0]  shift_amt_q, shift_amt_d;
  logic              blk_last_q, blk_last_d;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    cbfp_bank_fsm #(.lzc_w(lzc_w)) u_bank (
      .clk        (clk),
      .rstn       (rstn),
      .set_fill   (set_fill[g]),
      .set_full   (set_full[g]),
      .start_read (start_read[g]),
      .done_read  (done_read[g]),
      .exp_in     (blk_exp),
      .state      (bank_st[g]),
      .exp_out    (bank_exp[g])
    );
  end

  // Write/read steering, bank events and next-state of counters and outputs.
  always_comb begin
    any_reading = (bank_st[0] == READING) || (bank_st[1] == READING);

    // rstn gating keeps the combinational strobes at 0 while reset is held.
    rd_en     = rstn && (bank_st[rd_bank_q] == READING) && bus.rd_ready;
    rd_done   = rd_en && (rd_cnt_q == last_beat);
    done_read = {rd_done && rd_bank_q, rd_done && !rd_bank_q};
    start_read = {!any_reading && rd_bank_q  && (bank_st[1] == FULL),
                  !any_reading && !rd_bank_q && (bank_st[0] == FULL)};

    // A bank finishing read-out this cycle is already writable.
    wr_ok   = (bank_st[wr_bank_q] == EMPTY) || (bank_st[wr_bank_q] == FILLING) ||
              done_read[wr_bank_q];
    wr_en   = rstn && bus.valid_in && wr_ok;
    wr_last = (wr_cnt_q == last_beat);

    set_fill = {wr_en && wr_bank_q,  wr_en && !wr_bank_q} & {2{wr_cnt_q == '0}};
    set_full = {wr_en && wr_bank_q,  wr_en && !wr_bank_q} & {2{wr_last}};
    blk_exp  = lzc_w'(min_u(min_u(32'(run_min_q), 32'(bus.beat_lzc)), max_shift));

    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    run_min_d  = run_min_q;
    if (wr_en) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = !wr_bank_q;
        run_min_d = shift_sat;
      end else begin
        wr_cnt_d  = wr_cnt_q + 1'b1;
        run_min_d = lzc_w'(min_u(32'(run_min_q), 32'(bus.beat_lzc)));
      end
    end
    overflow_d = overflow_q || (bus.valid_in && !wr_ok);

    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (rd_en) begin
      rd_cnt_d = rd_done ? '0 : rd_cnt_q + 1'b1;
      if (rd_done) rd_bank_d = !rd_bank_q;
    end

    valid_out_d = rd_en;
    blk_last_d  = rd_done;
    shift_amt_d = rd_en ? bank_exp[rd_bank_q] : shift_amt_q;
  end

  // Sequencer state and the read-aligned output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      run_min_q   <= shift_sat;
      overflow_q  <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      valid_out_q <= 1'b0;
      shift_amt_q <= '0;
      blk_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      run_min_q   <= run_min_d;
      overflow_q  <= overflow_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      valid_out_q <= valid_out_d;
      shift_amt_q <= shift_amt_d;
      blk_last_q  <= blk_last_d;
    end
  end

`ifdef CBFP_STATS_EN
  logic [15:0] blk_count_q, blk_count_d;

  // Count blocks delivered downstream; wraps naturally at 2^16.
  always_comb begin
    blk_count_d = blk_count_q + 16'(valid_out_q && blk_last_q);
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (!rstn) blk_count_q <= '0;
    else       blk_count_q <= blk_count_d;
  end

  assign bus.blk_count = blk_count_q;
`else
  assign bus.blk_count = '0;
`endif

  assign bus.wr_en     = wr_en;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.wr_addr   = wr_cnt_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.rd_addr   = rd_cnt_q;
  assign bus.valid_out = valid_out_q;
  assign bus.shift_amt = shift_amt_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cbfp_blk_ctrl.sv
// Directed bench for cbfp_blk_ctrl with hand-computed expectations.
module tb_cbfp_blk_ctrl;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cbfp_blk_ctrl_if #(.addr_w(2), .lzc_w(5)) bus ();

  cbfp_blk_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Captured read-out beats
  logic [4:0] out_shift [$];
  logic       out_last  [$];

  always @(negedge clk) begin
    if (bus.valid_out) begin
      out_shift.push_back(bus.shift_amt);
      out_last.push_back(bus.blk_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_wr_en"},     32'(bus.wr_en), 0);
    chk({tag, "_wr_bank"},   32'(bus.wr_bank), 0);
    chk({tag, "_wr_addr"},   32'(bus.wr_addr), 0);
    chk({tag, "_rd_en"},     32'(bus.rd_en), 0);
    chk({tag, "_rd_bank"},   32'(bus.rd_bank), 0);
    chk({tag, "_rd_addr"},   32'(bus.rd_addr), 0);
    chk({tag, "_valid_out"}, 32'(bus.valid_out), 0);
    chk({tag, "_shift_amt"}, 32'(bus.shift_amt), 0);
    chk({tag, "_blk_last"},  32'(bus.blk_last), 0);
    chk({tag, "_overflow"},  32'(bus.overflow), 0);
    chk({tag, "_blk_count"}, 32'(bus.blk_count), 0);
  endtask

  // Drive one beat just after a falling edge; the posedge in between samples it.
  task automatic send_beat(input string tag, input logic [4:0] lzc, input logic exp_wr,
                           input logic exp_bank, input logic [1:0] exp_addr);
    bus.valid_in = 1'b1;
    bus.beat_lzc = lzc;
    #1;
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk({tag, "_wr_bank"}, 32'(bus.wr_bank), 32'(exp_bank));
      chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(exp_addr));
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic send_block(input string tag, input logic bank, input logic [4:0] l0,
                            input logic [4:0] l1, input logic [4:0] l2, input logic [4:0] l3);
    send_beat({tag, "_b0"}, l0, 1'b1, bank, 2'd0);
    send_beat({tag, "_b1"}, l1, 1'b1, bank, 2'd1);
    send_beat({tag, "_b2"}, l2, 1'b1, bank, 2'd2);
    send_beat({tag, "_b3"}, l3, 1'b1, bank, 2'd3);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 60 && out_shift.size() < n; i++) @(negedge clk);
    chk({tag, "_nbeats"}, 32'(out_shift.size()), 32'(n));
  endtask

  task automatic expect_block(input string tag, input logic [4:0] shift);
    for (int i = 0; i < 4; i++) begin
      if (out_shift.size() != 0) begin
        chk($sformatf("%s_shift%0d", tag, i), 32'(out_shift.pop_front()), 32'(shift));
        chk($sformatf("%s_last%0d", tag, i), 32'(out_last.pop_front()), 32'(i == 3));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b0;
    bus.valid_in = 1'b0;
    bus.beat_lzc = '0;
    bus.rd_ready = 1'b0;
    idle(3);
    check_idle("reset");
    rstn = 1'b1;

    // 1: single block, latency and shift = min(7,5,9,6)
    bus.rd_ready = 1'b1;
    out_shift.delete(); out_last.delete();
    send_block("t1", 1'b0, 5'd7, 5'd5, 5'd9, 5'd6);
    #1 chk("t1_rd_en_T1", 32'(bus.rd_en), 0);
    @(negedge clk); #1;
    chk("t1_rd_en_T2", 32'(bus.rd_en), 1);
    chk("t1_rd_addr_T2", 32'(bus.rd_addr), 0);
    chk("t1_rd_bank_T2", 32'(bus.rd_bank), 0);
    chk("t1_vout_T2", 32'(bus.valid_out), 0);
    @(negedge clk); #1;
    chk("t1_vout_T3", 32'(bus.valid_out), 1);
    chk("t1_shift_T3", 32'(bus.shift_amt), 5);
    chk("t1_rd_addr_T3", 32'(bus.rd_addr), 1);
    wait_beats("t1", 4);
    expect_block("t1", 5'd5);
    idle(4);

    // 2: two blocks with a 4-cycle gap, banks alternate
    out_shift.delete(); out_last.delete();
    send_block("t2a", 1'b1, 5'd8, 5'd3, 5'd10, 5'd4);
    idle(4);
    send_block("t2b", 1'b0, 5'd12, 5'd15, 5'd13, 5'd14);
    wait_beats("t2", 8);
    expect_block("t2a", 5'd3);
    expect_block("t2b", 5'd12);
    chk("t2_overflow", 32'(bus.overflow), 0);
    idle(4);

    // 3: large LZC saturates to max_shift
    out_shift.delete(); out_last.delete();
    send_block("t3", 1'b1, 5'd20, 5'd31, 5'd20, 5'd13);
    wait_beats("t3", 4);
    expect_block("t3", 5'd12);
    idle(4);

    // 4: reads stalled, third block dropped, overflow sticky
    out_shift.delete(); out_last.delete();
    bus.rd_ready = 1'b0;
    chk("t4_overflow_pre", 32'(bus.overflow), 0);
    send_block("t4a", 1'b0, 5'd4, 5'd6, 5'd2, 5'd9);
    send_block("t4b", 1'b1, 5'd11, 5'd7, 5'd8, 5'd10);
    for (int i = 0; i < 4; i++) send_beat($sformatf("t4drop%0d", i), 5'd0, 1'b0, 1'b0, 2'd0);
    idle(3);
    chk("t4_overflow", 32'(bus.overflow), 1);
    chk("t4_stall_beats", 32'(out_shift.size()), 0);
    chk("t4_stall_rd_en", 32'(bus.rd_en), 0);
    bus.rd_ready = 1'b1;
    wait_beats("t4", 8);
    idle(8);
    chk("t4_exact8", 32'(out_shift.size()), 8);
    expect_block("t4a", 5'd2);
    expect_block("t4b", 5'd7);
    chk("t4_overflow_sticky", 32'(bus.overflow), 1);

    // 5: reset mid-block discards the partial block
    out_shift.delete(); out_last.delete();
    send_beat("t5p0", 5'd1, 1'b1, 1'b0, 2'd0);
    send_beat("t5p1", 5'd1, 1'b1, 1'b0, 2'd1);
    rstn = 1'b0;
    idle(2);
    check_idle("t5rst");
    rstn = 1'b1;
    send_block("t5", 1'b0, 5'd9, 5'd8, 5'd11, 5'd10);
    wait_beats("t5", 4);
    expect_block("t5", 5'd8);
    chk("t5_overflow", 32'(bus.overflow), 0);
    idle(4);

    // 6: back-to-back blocks (bank freed and refilled in one cycle), then stats
    out_shift.delete(); out_last.delete();
    send_block("t6a", 1'b1, 5'd3, 5'd3, 5'd3, 5'd3);
    send_block("t6b", 1'b0, 5'd10, 5'd6, 5'd14, 5'd9);
    send_block("t6c", 1'b1, 5'd31, 5'd30, 5'd29, 5'd28);
    wait_beats("t6abc", 12);
    expect_block("t6a", 5'd3);
    expect_block("t6b", 5'd6);
    expect_block("t6c", 5'd12);
    idle(4);
    send_block("t6d", 1'b0, 5'd2, 5'd1, 5'd4, 5'd0);
    wait_beats("t6d", 4);
    expect_block("t6d", 5'd0);
    idle(2);
    chk("t6_overflow", 32'(bus.overflow), 0);
`ifdef CBFP_STATS_EN
    chk("t6_blk_count", 32'(bus.blk_count), 5);
`else
    chk("t6_blk_count", 32'(bus.blk_count), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
